// File: rtl/imem_loader.sv
// Byte-stream loader for instruction memory: packs little-endian bytes into
// 32-bit words, writes them at consecutive word addresses and holds the CPU.
module imem_loader #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len_words,
  input  logic                  in_valid,
  input  logic [7:0]            in_byte,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [31:0]           wr_addr,
  output logic [31:0]           wr_data,
  output logic                  busy,
  output logic                  cpu_hold,
  output logic                  done,
  output logic [31:0]           checksum
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [ADDR_WIDTH:0] len_q, len_d;
  // One bit wider than the address so a full-capacity load never wraps.
  logic [ADDR_WIDTH:0] word_idx_q, word_idx_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [23:0]         shift_q, shift_d;
  logic [31:0]         wr_addr_q, wr_addr_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic [31:0]         checksum_q, checksum_d;

  logic [ADDR_WIDTH:0] len_sat;
  logic                accept;
  logic                last_word;
  logic [31:0]         idx_ext;

  assign len_sat   = (len_words > MAX_LEN) ? MAX_LEN : len_words;
  assign accept    = (state_q == S_LOAD) && in_valid;
  assign last_word = (word_idx_q == (len_q - ONE));
  assign idx_ext   = 32'(word_idx_q);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      checksum_q <= checksum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (len_sat == '0) ? S_DONE : S_LOAD;
      S_LOAD:  if (accept && (byte_cnt_q == 2'd3)) state_d = S_WRITE;
      S_WRITE: state_d = last_word ? S_DONE : S_LOAD;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Write address/data are captured with the 4th byte so they are stable
  // registers during the WRITE cycle.
  always_comb begin
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    checksum_d = checksum_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d      = len_sat;
          word_idx_d = '0;
          byte_cnt_d = '0;
          checksum_d = '0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: shift_d[7:0]   = in_byte;
            2'd1: shift_d[15:8]  = in_byte;
            2'd2: shift_d[23:16] = in_byte;
            default: begin
              wr_data_d = {in_byte, shift_q};
              wr_addr_d = idx_ext << 2;
            end
          endcase
        end
      end
      S_WRITE: begin
        checksum_d = checksum_q + wr_data_q;
        word_idx_d = word_idx_q + ONE;
        byte_cnt_d = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_LOAD);
    wr_en    = (state_q == S_WRITE);
    busy     = (state_q != S_IDLE);
    cpu_hold = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    wr_addr  = wr_addr_q;
    wr_data  = wr_data_q;
    checksum = checksum_q;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader (ADDR_WIDTH=2): scenario tasks drive byte streams and
// compare observed writes, checksum and timing against a queue-based model.
module tb_imem_loader;
  localparam int AW  = 2;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   len_words = '0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_byte = '0;
  logic          in_ready, wr_en, busy, cpu_hold, done;
  logic [31:0]   wr_addr, wr_data, checksum;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .len_words(len_words),
    .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .cpu_hold(cpu_hold), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int pcyc = 0, done_cnt = 0, done_edge = 0, busy_cnt = 0, hold_bad = 0;
  int sedge, d0, busy0, load_edges, load_busy, load_dones;
  logic [31:0] wa_q[$], wd_q[$], exp_words[$];

  always @(posedge clk) pcyc++;

  always @(negedge clk) begin
    if (wr_en) begin wa_q.push_back(wr_addr); wd_q.push_back(wr_data); end
    if (done) begin done_cnt++; done_edge = pcyc; end
    if (busy) busy_cnt++;
    if (cpu_hold !== busy) hold_bad++;
  end

  function automatic int eff_len(input int req);
    return (req > CAP) ? CAP : req;
  endfunction

  function automatic logic [31:0] exp_sum();
    logic [31:0] s = 0;
    foreach (exp_words[i]) s += exp_words[i];
    return s;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    if (gap > 0) begin in_valid = 1'b0; repeat (gap) @(negedge clk); end
    in_valid = 1'b1; in_byte = b;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL send_byte_timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic do_load(input int len_req, input int max_gap);
    int t = 0;
    @(negedge clk);
    wa_q.delete(); wd_q.delete();
    d0 = done_cnt; busy0 = busy_cnt;
    start = 1'b1; len_words = len_req[AW:0];
    @(negedge clk);
    start = 1'b0; sedge = pcyc;
    foreach (exp_words[i])
      for (int k = 0; k < 4; k++) send_byte(exp_words[i][8*k +: 8], int'($urandom_range(max_gap, 0)));
    in_valid = 1'b0;
    while (done_cnt == d0 && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: done_cnt=%0d required >%0d", done_cnt, d0);
    end
    @(negedge clk);
    load_edges = done_edge - sedge;
    load_busy  = busy_cnt - busy0;
    load_dones = done_cnt - d0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      start = 1'($urandom); in_valid = 1'($urandom); in_byte = 8'($urandom);
      n_checks++;
      if ({in_ready, wr_en, busy, cpu_hold, done, wr_addr, wr_data, checksum} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: rdy=%b wr=%b busy=%b hold=%b done=%b addr=%h data=%h sum=%h required all 0",
                 in_ready, wr_en, busy, cpu_hold, done, wr_addr, wr_data, checksum);
      end
    end
    start = 1'b0;
    @(negedge clk); resetn = 1'b1;
    repeat (4) begin
      @(negedge clk); in_valid = 1'($urandom);
      n_checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL idle_no_start: in_ready=%b busy=%b required 0 0", in_ready, busy);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_single_word();
    exp_words = '{32'h12345678};
    do_load(1, 0);
    n_checks++;
    if (wa_q.size() !== 1) begin n_fail++; $display("FAIL single_nwrites: got %0d required 1", wa_q.size()); end
    else begin
      n_checks++;
      if (wa_q[0] !== 32'h0 || wd_q[0] !== 32'h12345678) begin
        n_fail++; $display("FAIL single_write: addr=%h data=%h required 0 12345678", wa_q[0], wd_q[0]);
      end
    end
    n_checks++;
    if (checksum !== 32'h12345678) begin n_fail++; $display("FAIL single_checksum: got %h required 12345678", checksum); end
    n_checks++;
    if (load_edges !== 5 || load_dones !== 1) begin
      n_fail++; $display("FAIL single_done_timing: edges=%0d dones=%0d required 5 1", load_edges, load_dones);
    end
  endtask

  task automatic test_gaps();
    exp_words = '{32'hFFFFFFFF, 32'h00000002, 32'h80000000};
    hold_bad = 0;
    do_load(3, 3);
    n_checks++;
    if (wa_q.size() !== 3) begin n_fail++; $display("FAIL gaps_nwrites: got %0d required 3", wa_q.size()); end
    for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
      n_checks++;
      if (wa_q[i] !== 32'(i * 4) || wd_q[i] !== exp_words[i]) begin
        n_fail++; $display("FAIL gaps_write%0d: addr=%h data=%h required %h %h", i, wa_q[i], wd_q[i], i * 4, exp_words[i]);
      end
    end
    n_checks++;
    if (checksum !== 32'h80000001) begin n_fail++; $display("FAIL gaps_checksum: got %h required 80000001", checksum); end
    n_checks++;
    if (load_busy !== load_edges + 1 || load_edges < 15 || hold_bad !== 0) begin
      n_fail++; $display("FAIL gaps_busy_hold: busy_cycles=%0d edges=%0d hold_bad=%0d required edges+1 >=15 0",
                         load_busy, load_edges, hold_bad);
    end
  endtask

  task automatic test_len0_sat();
    exp_words.delete();
    do_load(0, 0);
    n_checks++;
    if (wa_q.size() !== 0 || load_edges !== 0 || load_busy !== 1 || load_dones !== 1) begin
      n_fail++; $display("FAIL len0: writes=%0d edges=%0d busy_cycles=%0d dones=%0d required 0 0 1 1",
                         wa_q.size(), load_edges, load_busy, load_dones);
    end
    for (int i = 0; i < CAP; i++) exp_words.push_back($urandom);
    do_load(7, 0);
    n_checks++;
    if (wa_q.size() !== CAP) begin n_fail++; $display("FAIL sat_nwrites: got %0d required %0d", wa_q.size(), CAP); end
    else begin
      n_checks++;
      if (wa_q[CAP-1] !== 32'((CAP - 1) * 4)) begin
        n_fail++; $display("FAIL sat_last_addr: got %h required %h", wa_q[CAP-1], (CAP - 1) * 4);
      end
    end
    n_checks++;
    if (checksum !== exp_sum() || load_edges !== 5 * CAP) begin
      n_fail++; $display("FAIL sat_sum_timing: sum=%h edges=%0d required %h %0d", checksum, load_edges, exp_sum(), 5 * CAP);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    wa_q.delete();
    start = 1'b1; len_words = 3'd2;
    @(negedge clk); start = 1'b0;
    send_byte(8'hA1, 0);
    send_byte(8'hB2, 0);
    in_byte = 8'hC3;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1; in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || checksum !== 32'h0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL midreset_state: busy=%b sum=%h rdy=%b required 0 0 0", busy, checksum, in_ready);
    end
    repeat (6) @(negedge clk);
    n_checks++;
    if (wa_q.size() !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_nowrite: writes=%0d busy=%b required 0 0", wa_q.size(), busy);
    end
    exp_words = '{$urandom, $urandom};
    do_load(2, 1);
    n_checks++;
    if (wa_q.size() !== 2 || checksum !== exp_sum()) begin
      n_fail++; $display("FAIL midreset_reload: writes=%0d sum=%h required 2 %h", wa_q.size(), checksum, exp_sum());
    end else begin
      n_checks++;
      if (wa_q[0] !== 32'h0 || wa_q[1] !== 32'h4 || wd_q[0] !== exp_words[0] || wd_q[1] !== exp_words[1]) begin
        n_fail++; $display("FAIL midreset_writes: %h:%h %h:%h required 0:%h 4:%h",
                           wa_q[0], wd_q[0], wa_q[1], wd_q[1], exp_words[0], exp_words[1]);
      end
    end
  endtask

  task automatic test_start_busy();
    exp_words = '{$urandom, $urandom};
    fork
      do_load(2, 0);
      begin
        int t = 0;
        repeat (3) @(negedge clk);
        start = 1'b1; len_words = 3'd1;
        @(negedge clk); start = 1'b0;
        while (!wr_en && t < 50) begin @(negedge clk); t++; end
        start = 1'b1; len_words = 3'd3;
        @(negedge clk); start = 1'b0;
      end
    join
    n_checks++;
    if (wa_q.size() !== 2 || load_dones !== 1 || load_edges !== 10) begin
      n_fail++; $display("FAIL busy_start_ignored: writes=%0d dones=%0d edges=%0d required 2 1 10",
                         wa_q.size(), load_dones, load_edges);
    end else begin
      n_checks++;
      if (wa_q[1] !== 32'h4 || wd_q[0] !== exp_words[0] || wd_q[1] !== exp_words[1] || checksum !== exp_sum()) begin
        n_fail++; $display("FAIL busy_start_data: addr1=%h d0=%h d1=%h sum=%h required 4 %h %h %h",
                           wa_q[1], wd_q[0], wd_q[1], checksum, exp_words[0], exp_words[1], exp_sum());
      end
    end
  endtask

  task automatic test_random();
    repeat (4) begin
      int req = int'($urandom_range(7, 1));
      int gap = int'($urandom_range(3, 0));
      int n   = eff_len(req);
      exp_words.delete();
      for (int i = 0; i < n; i++) exp_words.push_back($urandom);
      do_load(req, gap);
      n_checks++;
      if (wa_q.size() !== n || checksum !== exp_sum() || load_dones !== 1) begin
        n_fail++; $display("FAIL rand_load len=%0d: writes=%0d sum=%h dones=%0d required %0d %h 1",
                           req, wa_q.size(), checksum, load_dones, n, exp_sum());
      end
      for (int i = 0; i < n && i < wa_q.size(); i++) begin
        n_checks++;
        if (wa_q[i] !== 32'(i * 4) || wd_q[i] !== exp_words[i]) begin
          n_fail++; $display("FAIL rand_write%0d: addr=%h data=%h required %h %h", i, wa_q[i], wd_q[i], i * 4, exp_words[i]);
        end
      end
      n_checks++;
      if ((gap == 0 && load_edges !== 5 * n) || load_edges < 5 * n) begin
        n_fail++; $display("FAIL rand_timing len=%0d gap=%0d: edges=%0d required %0d", req, gap, load_edges, 5 * n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_gaps();
    test_len0_sat();
    test_reset_mid();
    test_start_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
